// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 slave front end.
//   - spi_state_e      : FSM states of the slave (idle / shifting a frame)
//   - DATA_WIDTH_DEF   : default SPI word width
//   - SYNC_STAGES_MIN  : smallest legal synchroniser depth
package spi_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int SYNC_STAGES_MIN = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with an optional
// extra flop that provides single-cycle rise/fall strobes.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   d_i        asynchronous input
//   q_o        synchronised level (STAGES clk edges of delay)
//   rise_o     1 for one cycle when q_o goes 0->1 (0 when EDGE_EN=0)
//   fall_o     1 for one cycle when q_o goes 1->0 (0 when EDGE_EN=0)
// STAGES must be at least spi_pkg::SYNC_STAGES_MIN.
module spi_sync_edge #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;

    // Synchroniser chain; the input enters at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

    // The edge strobes are combinational on the last synchroniser stage so
    // that a strobe is valid right after the edge that makes q_o change.
    generate
        if (EDGE_EN) begin : g_edge
            logic prev_q;

            // Previous value of the synchronised level, for edge detection.
            always_ff @(posedge clk) begin
                if (rst) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= sync_q[STAGES-1];
                end
            end

            assign rise_o = sync_q[STAGES-1] & ~prev_q;
            assign fall_o = ~sync_q[STAGES-1] & prev_q;
        end else begin : g_no_edge
            assign rise_o = 1'b0;
            assign fall_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 (CPOL=0, CPHA=0) slave front end, fully in the clk domain.
// SCK, CS_n and MOSI are oversampled; MOSI words are delivered as a
// one-cycle rx_valid strobe with rx_data, and a word from the core's TX
// holding buffer is serialised on MISO during the next word slot.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   spi_sck      SPI clock (async, idles low)
//   spi_cs_n     chip select (async, active-low)
//   spi_mosi     serial in, MSB first
//   spi_miso     serial out, MSB first, 0 while not selected
//   rx_data      last complete received word (held)
//   rx_valid     one-cycle strobe, rx_data updated
//   tx_data      word for the next slot; captured when tx_load=1
//   tx_load      write tx_data into the holding buffer
//   tx_empty     holding buffer has no unsent word
//   busy         synchronised CS asserted (frame in progress)
//   frame_err    one-cycle strobe, CS released mid-word
// DATA_WIDTH must be at least 3.
module spi_slave import spi_pkg::*; #(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_empty,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int              DW       = DATA_WIDTH;
    localparam int              CW       = $clog2(DW);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_LAST = CW'(DW - 1);

    // Synchronised pins.
    logic sck_s, sck_rise_s, sck_fall_s;
    logic cs_n_s, mosi_s;
    logic cs_rise_s, cs_fall_s, mosi_rise_s, mosi_fall_s;
    logic unused_sync_s;

    // State and datapath registers.
    spi_state_e      state_q,     state_d;
    logic [CW-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [DW-2:0]   rx_shift_q,  rx_shift_d;
    logic [DW-1:0]   rx_data_q,   rx_data_d;
    logic            rx_valid_q,  rx_valid_d;
    logic [DW-1:0]   tx_shift_q,  tx_shift_d;
    logic [DW-1:0]   tx_buf_q,    tx_buf_d;
    logic            tx_empty_q,  tx_empty_d;
    logic            frame_err_q, frame_err_d;
    logic            busy_q,      busy_d;
    logic            miso_q,      miso_d;
    logic            armed_q,     armed_d;
    logic            reload_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sck (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi_sck),
        .q_o    (sck_s),
        .rise_o (sck_rise_s),
        .fall_o (sck_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_cs (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi_cs_n),
        .q_o    (cs_n_s),
        .rise_o (cs_rise_s),
        .fall_o (cs_fall_s)
    );

    // MOSI goes through the same depth as SCK so the bit sampled on
    // sck_rise is the one the master presented before that SCK edge.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi_mosi),
        .q_o    (mosi_s),
        .rise_o (mosi_rise_s),
        .fall_o (mosi_fall_s)
    );

    assign unused_sync_s = &{sck_s, cs_rise_s, cs_fall_s, mosi_rise_s, mosi_fall_s};

    // Next-state logic: frame FSM, RX/TX shifters and the TX holding buffer.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        tx_buf_d    = tx_buf_q;
        tx_empty_d  = tx_empty_q;
        frame_err_d = 1'b0;
        reload_s    = 1'b0;
        // A CS that is already low when reset releases must not start a
        // frame: entry into SHIFT needs CS to have been seen high first.
        armed_d     = armed_q | cs_n_s;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = CNT_ZERO;
                if (armed_q && !cs_n_s) begin
                    state_d  = ST_SHIFT;
                    reload_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cs_n_s) begin
                    // Deselect wins over any SCK edge seen in the same cycle.
                    state_d   = ST_IDLE;
                    bit_cnt_d = CNT_ZERO;
                    if (bit_cnt_q != CNT_ZERO) begin
                        frame_err_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b0;
                    end
                end else if (sck_rise_s) begin
                    rx_shift_d = {rx_shift_q[DW-3:0], mosi_s};
                    if (bit_cnt_q == CNT_LAST) begin
                        rx_data_d  = {rx_shift_q, mosi_s};
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = CNT_ZERO;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end else if (sck_fall_s) begin
                    // Falling edge after the last bit of a word starts the
                    // next word slot; otherwise present the next bit.
                    if (bit_cnt_q == CNT_ZERO) begin
                        reload_s = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[DW-2:0], 1'b0};
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = CNT_ZERO;
            end
        endcase

        // A reload always consumes the buffer's old contents (zeros if
        // nothing is pending); a load in the same cycle refills it.
        if (reload_s) begin
            tx_shift_d = tx_empty_q ? {DW{1'b0}} : tx_buf_q;
            tx_empty_d = 1'b1;
        end else begin
            tx_empty_d = tx_empty_q;
        end

        if (tx_load) begin
            tx_buf_d   = tx_data;
            tx_empty_d = 1'b0;
        end else begin
            tx_buf_d = tx_buf_q;
        end

        busy_d = (state_d == ST_SHIFT);
        miso_d = busy_d ? tx_shift_d[DW-1] : 1'b0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= CNT_ZERO;
            rx_shift_q  <= {(DW-1){1'b0}};
            rx_data_q   <= {DW{1'b0}};
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= {DW{1'b0}};
            tx_buf_q    <= {DW{1'b0}};
            tx_empty_q  <= 1'b1;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            miso_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_empty_q  <= tx_empty_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            miso_q      <= miso_d;
            armed_q     <= armed_d;
        end
    end

    assign spi_miso  = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_empty  = tx_empty_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave acting as an SPI mode-0 master at
// f_clk = 16 * f_sck. A transaction-level model (expected word queue,
// TX buffer full/empty, expected strobe cycles) is checked by one
// per-cycle compare process; the master checks MISO bits as it clocks.
module tb_spi_slave;

    localparam int DW   = 8;
    localparam int S    = 2;
    localparam int HALF = 8;   // clk cycles per SCK half period

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } ev_t;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          spi_sck  = 1'b0;
    logic          spi_cs_n = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          tx_load  = 1'b0;
    logic [DW-1:0] tx_data  = 8'h00;
    logic          spi_miso, rx_valid, tx_empty, busy, frame_err;
    logic [DW-1:0] rx_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state.
    ev_t           exp_rx_q[$];
    int            exp_fe_q[$];
    logic [DW-1:0] m_buf  = 8'h00;
    bit            m_full = 1'b0;
    logic [DW-1:0] m_cur  = 8'h00;

    logic [DW-1:0] w0, w1;

    spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_sck   (spi_sck),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_empty  (tx_empty),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: start of a word slot takes the buffer (zeros if empty).
    task automatic model_reload();
        m_cur  = m_full ? m_buf : 8'h00;
        m_full = 1'b0;
    endtask

    task automatic model_load(input logic [DW-1:0] d);
        m_buf  = d;
        m_full = 1'b1;
    endtask

    task automatic load_idle(input logic [DW-1:0] d);
        tx_data = d;
        tx_load = 1'b1;
        model_load(d);
        tick(1);
        tx_load = 1'b0;
        tick(3);
    endtask

    // Drop CS; optionally pulse tx_load in the exact cycle of the reload
    // (CS synchronised after S edges, reload registered on the next one).
    task automatic cs_low(input bit same_cycle_load, input logic [DW-1:0] d);
        spi_cs_n = 1'b0;
        model_reload();
        if (same_cycle_load) begin
            tick(S);
            tx_data = d;
            tx_load = 1'b1;
            model_load(d);
            tick(1);
            tx_load = 1'b0;
            tick(HALF - S - 1);
        end else begin
            tick(HALF);
        end
    endtask

    task automatic cs_high(input bit partial);
        tick(HALF);
        spi_cs_n = 1'b1;
        if (partial) exp_fe_q.push_back(cyc + S + 1);
        tick(2 * HALF);
        check("busy_after_cs_high", busy, 1'b0);
        check("miso_deselected", spi_miso, 1'b0);
    endtask

    // Clock nbits bits of mosi_w (MSB first); MISO sampled just before
    // each rising edge. Optional tx_load at the start of the second bit.
    task automatic send_word(input logic [DW-1:0] mosi_w, input int nbits,
                             input bit do_load, input logic [DW-1:0] ld,
                             output logic [DW-1:0] miso_w);
        miso_w = 8'h00;
        for (int i = DW - 1; i >= DW - nbits; i--) begin
            spi_mosi = mosi_w[i];
            if (do_load && i == DW - 2) begin
                tx_data = ld;
                tx_load = 1'b1;
                model_load(ld);
                tick(1);
                tx_load = 1'b0;
                tick(HALF - 1);
            end else begin
                tick(HALF);
            end
            miso_w[i] = spi_miso;
            check("miso_bit", spi_miso, m_cur[i]);
            check("busy_in_frame", busy, 1'b1);
            check("tx_empty", tx_empty, !m_full);
            spi_sck = 1'b1;
            if (i == 0) exp_rx_q.push_back('{data: mosi_w, due: cyc + S + 1});
            tick(HALF);
            spi_sck = 1'b0;
        end
        if (nbits == DW) model_reload();
    endtask

    // Per-cycle compare of rx_valid/rx_data/frame_err against the model.
    initial begin : compare_proc
        ev_t           e;
        logic [DW-1:0] last_rx = 8'h00;
        logic          prev_rv = 1'b0;
        logic          prev_fe = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_rx = 8'h00;
                prev_rv = 1'b0;
                prev_fe = 1'b0;
            end else begin
                if (rx_valid) begin
                    check("rx_valid_single", prev_rv, 1'b0);
                    if (exp_rx_q.size() == 0) begin
                        check("rx_valid_unexpected", 1'b1, 1'b0);
                    end else begin
                        e = exp_rx_q.pop_front();
                        check("rx_data", rx_data, e.data);
                        check("rx_valid_cycle", cyc, e.due);
                        last_rx = e.data;
                    end
                end else if (exp_rx_q.size() != 0 && cyc > exp_rx_q[0].due) begin
                    check("rx_valid_missing", 1'b0, 1'b1);
                    void'(exp_rx_q.pop_front());
                end
                check("rx_data_hold", rx_data, last_rx);
                if (frame_err) begin
                    check("frame_err_single", prev_fe, 1'b0);
                    if (exp_fe_q.size() == 0) begin
                        check("frame_err_unexpected", 1'b1, 1'b0);
                    end else begin
                        check("frame_err_cycle", cyc, exp_fe_q.pop_front());
                    end
                end else if (exp_fe_q.size() != 0 && cyc > exp_fe_q[0]) begin
                    check("frame_err_missing", 1'b0, 1'b1);
                    void'(exp_fe_q.pop_front());
                end
                prev_rv = rx_valid;
                prev_fe = frame_err;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"}, spi_miso, 1'b0);
        check({tag, "_rx_data"}, rx_data, 8'h00);
        check({tag, "_rx_valid"}, rx_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_frame_err"}, frame_err, 1'b0);
        check({tag, "_tx_empty"}, tx_empty, 1'b1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        tick(4);
        rst = 1'b0;
        tick(1);
        check_reset_values("reset");
        tick(4);

        // 1: receive 0xA5, buffer empty so MISO sends zeros.
        cs_low(1'b0, 8'h00);
        send_word(8'hA5, DW, 1'b0, 8'h00, w0);
        cs_high(1'b0);
        check("t1_rx_data", rx_data, 8'hA5);
        check("t1_miso_word", w0, 8'h00);

        // 2: preload 0x3C, sent MSB first; buffer empties at CS-low reload.
        load_idle(8'h3C);
        check("t2_tx_empty_loaded", tx_empty, 1'b0);
        cs_low(1'b0, 8'h00);
        check("t2_tx_empty_reload", tx_empty, 1'b1);
        send_word(8'h00, DW, 1'b0, 8'h00, w0);
        check("t2_miso_word", w0, 8'h3C);
        cs_high(1'b0);

        // 3: two-word frame, load 0x5A during word 1.
        cs_low(1'b0, 8'h00);
        send_word(8'h12, DW, 1'b1, 8'h5A, w0);
        send_word(8'h34, DW, 1'b0, 8'h00, w1);
        cs_high(1'b0);
        check("t3_miso_word1", w0, 8'h00);
        check("t3_miso_word2", w1, 8'h5A);
        check("t3_rx_data", rx_data, 8'h34);

        // 4: CS released after 5 bits -> frame_err, no word; then 0xFF.
        cs_low(1'b0, 8'h00);
        send_word(8'hFF, 5, 1'b0, 8'h00, w0);
        cs_high(1'b1);
        check("t4_rx_data_unchanged", rx_data, 8'h34);
        cs_low(1'b0, 8'h00);
        send_word(8'hFF, DW, 1'b0, 8'h00, w0);
        cs_high(1'b0);
        check("t4_rx_data", rx_data, 8'hFF);

        // 5: load 0x77 in the same cycle as the reload of 0x11.
        load_idle(8'h11);
        cs_low(1'b1, 8'h77);
        check("t5_tx_empty_kept", tx_empty, 1'b0);
        send_word(8'h5E, DW, 1'b0, 8'h00, w0);
        send_word(8'h00, DW, 1'b0, 8'h00, w1);
        cs_high(1'b0);
        check("t5_miso_word1", w0, 8'h11);
        check("t5_miso_word2", w1, 8'h77);
        check("t5_tx_empty_end", tx_empty, 1'b1);

        // 6: reset at bit 4 with CS held low.
        cs_low(1'b0, 8'h00);
        send_word(8'hC3, 4, 1'b0, 8'h00, w0);
        rst = 1'b1;
        exp_rx_q.delete();
        exp_fe_q.delete();
        m_full = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_reset_values("midframe_reset");
        for (int k = 0; k < DW; k++) begin
            spi_sck = 1'b1;
            tick(HALF);
            spi_sck = 1'b0;
            tick(HALF);
        end
        check("t6_busy_cs_ignored", busy, 1'b0);
        check("t6_rx_data_still_reset", rx_data, 8'h00);
        cs_high(1'b0);
        cs_low(1'b0, 8'h00);
        send_word(8'hC3, DW, 1'b0, 8'h00, w0);
        cs_high(1'b0);
        check("t6_rx_data", rx_data, 8'hC3);

        tick(10);
        check("pending_rx_events", exp_rx_q.size(), 32'd0);
        check("pending_fe_events", exp_fe_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
